// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: types and constants shared by the memory port arbiter.
//   arb_state_e : FSM state encoding (IDLE=0, ACCESS=1, RESP=2), visible on STATE
//   WIDTH_DEF   : default address/data word width
//   MEM_LAT_MAX : largest supported memory latency; sizes the latency counter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam int WIDTH_DEF   = 9;
  localparam int MEM_LAT_MAX = 8;
  // The counter only has to reach MEM_LAT-1, so 0..7 fits in 3 bits.
  localparam int CNT_W       = $clog2(MEM_LAT_MAX);

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational two-way round-robin picker.
//   REQ0, REQ1 : pending requests
//   PRI        : requester that wins when both are pending
//   VALID      : at least one request pending
//   WINNER     : index of the selected requester (meaningful when VALID)
module mem_arb_pick (
  input  logic REQ0,
  input  logic REQ1,
  input  logic PRI,
  output logic VALID,
  output logic WINNER
);

  always_comb begin
    VALID  = REQ0 | REQ1;
    // A lone request wins outright; a tie goes to the priority holder.
    WINNER = (REQ0 & REQ1) ? PRI : REQ1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between two masters.
//   CLK, RST                   : clock, synchronous active-low reset
//   REQx, Wx, ADDRx, DOUTx     : requester x transaction (held until ACKx)
//   GNTx                       : requester x owns the port
//   ACKx                       : one-cycle completion pulse for requester x
//   RDATA                      : read data, valid while ACKx is high
//   MADDR, MDOUT, MW           : memory address, write data, write strobe
//   MDIN                       : memory read data
//   STATE                      : FSM state (IDLE=0, ACCESS=1, RESP=2)
// Every output comes straight from a register.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int MEM_LAT = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic             W0,
  input  logic [WIDTH-1:0] ADDR0,
  input  logic [WIDTH-1:0] DOUT0,
  output logic             GNT0,
  output logic             ACK0,
  input  logic             REQ1,
  input  logic             W1,
  input  logic [WIDTH-1:0] ADDR1,
  input  logic [WIDTH-1:0] DOUT1,
  output logic             GNT1,
  output logic             ACK1,
  output logic [WIDTH-1:0] RDATA,
  output logic [WIDTH-1:0] MADDR,
  output logic [WIDTH-1:0] MDOUT,
  output logic             MW,
  input  logic [WIDTH-1:0] MDIN,
  output logic [1:0]       STATE
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pri_q, pri_d;
  logic             sel_q, sel_d;   // requester being served
  logic             wr_q, wr_d;     // served transaction is a write
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             mw_q, mw_d;
  logic [WIDTH-1:0] maddr_q, maddr_d;
  logic [WIDTH-1:0] mdout_q, mdout_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic pick_valid;
  logic pick_winner;

  mem_arb_pick u_pick (
    .REQ0   (REQ0),
    .REQ1   (REQ1),
    .PRI    (pri_q),
    .VALID  (pick_valid),
    .WINNER (pick_winner)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pri_d   = pri_q;
    sel_d   = sel_q;
    wr_d    = wr_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    mw_d    = 1'b0;   // strobe is high only in the first ACCESS cycle
    maddr_d = maddr_q;
    mdout_d = mdout_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = ACCESS;
          cnt_d   = '0;
          sel_d   = pick_winner;
          wr_d    = pick_winner ? W1 : W0;
          mw_d    = pick_winner ? W1 : W0;
          maddr_d = pick_winner ? ADDR1 : ADDR0;
          mdout_d = pick_winner ? DOUT1 : DOUT0;
          gnt0_d  = ~pick_winner;
          gnt1_d  = pick_winner;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = RESP;
          if (!wr_q) rdata_d = MDIN;
          // ACK is registered, so it is launched here to appear during RESP.
          ack0_d  = ~sel_q;
          ack1_d  = sel_q;
        end
      end
      RESP: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        pri_d   = ~sel_q;   // the other requester wins the next tie
      end
      default: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pri_q   <= 1'b0;
      sel_q   <= 1'b0;
      wr_q    <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      mw_q    <= 1'b0;
      maddr_q <= '0;
      mdout_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pri_q   <= pri_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      mw_q    <= mw_d;
      maddr_q <= maddr_d;
      mdout_q <= mdout_d;
      rdata_q <= rdata_d;
    end
  end

  assign GNT0  = gnt0_q;
  assign GNT1  = gnt1_q;
  assign ACK0  = ack0_q;
  assign ACK1  = ack1_q;
  assign MW    = mw_q;
  assign MADDR = maddr_q;
  assign MDOUT = mdout_q;
  assign RDATA = rdata_q;
  assign STATE = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter at MEM_LAT=2,
// plus two extra instances at MEM_LAT=1 and MEM_LAT=8 for the latency sweep.
module tb_mem_port_arbiter;

  logic       CLK;
  logic       RST;
  logic       REQ0, W0, REQ1, W1;
  logic [8:0] ADDR0, DOUT0, ADDR1, DOUT1;
  logic       GNT0, ACK0, GNT1, ACK1, MW;
  logic [8:0] RDATA, MADDR, MDOUT, MDIN;
  logic [1:0] STATE;

  logic [8:0] mem [0:511];

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.WIDTH(9), .MEM_LAT(2)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .W0(W0), .ADDR0(ADDR0), .DOUT0(DOUT0), .GNT0(GNT0), .ACK0(ACK0),
    .REQ1(REQ1), .W1(W1), .ADDR1(ADDR1), .DOUT1(DOUT1), .GNT1(GNT1), .ACK1(ACK1),
    .RDATA(RDATA), .MADDR(MADDR), .MDOUT(MDOUT), .MW(MW), .MDIN(MDIN), .STATE(STATE)
  );

  // Latency sweep instances (requester 1 idle, fixed read data).
  logic       req_l1, req_l8;
  logic       gnt0_l1, ack0_l1, gnt1_l1, ack1_l1, mw_l1;
  logic       gnt0_l8, ack0_l8, gnt1_l8, ack1_l8, mw_l8;
  logic [8:0] rdata_l1, maddr_l1, mdout_l1, rdata_l8, maddr_l8, mdout_l8;
  logic [1:0] state_l1, state_l8;
  logic [8:0] mdin_l1, mdin_l8;
  logic       zero1;
  logic [8:0] zero9;
  assign mdin_l1 = 9'h1C3;
  assign mdin_l8 = 9'h0B7;
  assign zero1   = 1'b0;
  assign zero9   = 9'h000;

  mem_port_arbiter #(.WIDTH(9), .MEM_LAT(1)) dut_l1 (
    .CLK(CLK), .RST(RST),
    .REQ0(req_l1), .W0(W0), .ADDR0(ADDR0), .DOUT0(DOUT0), .GNT0(gnt0_l1), .ACK0(ack0_l1),
    .REQ1(zero1), .W1(zero1), .ADDR1(zero9), .DOUT1(zero9), .GNT1(gnt1_l1), .ACK1(ack1_l1),
    .RDATA(rdata_l1), .MADDR(maddr_l1), .MDOUT(mdout_l1), .MW(mw_l1), .MDIN(mdin_l1),
    .STATE(state_l1)
  );

  mem_port_arbiter #(.WIDTH(9), .MEM_LAT(8)) dut_l8 (
    .CLK(CLK), .RST(RST),
    .REQ0(req_l8), .W0(W0), .ADDR0(ADDR0), .DOUT0(DOUT0), .GNT0(gnt0_l8), .ACK0(ack0_l8),
    .REQ1(zero1), .W1(zero1), .ADDR1(zero9), .DOUT1(zero9), .GNT1(gnt1_l8), .ACK1(ack1_l8),
    .RDATA(rdata_l8), .MADDR(maddr_l8), .MDOUT(mdout_l8), .MW(mw_l8), .MDIN(mdin_l8),
    .STATE(state_l8)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Simple memory behind the main instance: combinational read, write on strobe.
  assign MDIN = mem[MADDR];
  always @(posedge CLK) if (MW === 1'b1) mem[MADDR] <= MDOUT;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mutual exclusion of grants and acks, checked every cycle.
  always @(negedge CLK) begin
    checks++;
    assert ((GNT0 & GNT1) !== 1'b1)
    else begin
      errors++;
      $error("FAIL gnt_mutex: observed GNT0=%b GNT1=%b expected not both", GNT0, GNT1);
    end
    checks++;
    assert ((ACK0 & ACK1) !== 1'b1)
    else begin
      errors++;
      $error("FAIL ack_mutex: observed ACK0=%b ACK1=%b expected not both", ACK0, ACK1);
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 9'h000;
    mem[9'h040] = 9'h0F3;
    RST = 1'b0;
    REQ0 = 1'b1; W0 = 1'b0; ADDR0 = 9'h000; DOUT0 = 9'h000;
    REQ1 = 1'b0; W1 = 1'b0; ADDR1 = 9'h000; DOUT1 = 9'h000;
    req_l1 = 1'b0; req_l8 = 1'b0;

    // ---- Reset held two cycles with REQ0 high ----
    tick();
    chk("rst1_gnt0", GNT0, 0);
    chk("rst1_state", STATE, 0);
    tick();
    chk("rst_gnt0", GNT0, 0);
    chk("rst_gnt1", GNT1, 0);
    chk("rst_ack0", ACK0, 0);
    chk("rst_ack1", ACK1, 0);
    chk("rst_mw", MW, 0);
    chk("rst_maddr", MADDR, 0);
    chk("rst_mdout", MDOUT, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_state", STATE, 0);
    REQ0 = 1'b0; RST = 1'b1;
    tick();
    chk("idle_state", STATE, 0);
    $display("reset: done");

    // ---- Single write from requester 0 ----
    REQ0 = 1'b1; W0 = 1'b1; ADDR0 = 9'h012; DOUT0 = 9'h1A5;
    tick();  // cycle 1
    chk("wr_c1_maddr", MADDR, 9'h012);
    chk("wr_c1_mdout", MDOUT, 9'h1A5);
    chk("wr_c1_mw", MW, 1);
    chk("wr_c1_gnt0", GNT0, 1);
    chk("wr_c1_state", STATE, 1);
    chk("wr_c1_ack0", ACK0, 0);
    tick();  // cycle 2
    chk("wr_c2_mw", MW, 0);
    chk("wr_c2_gnt0", GNT0, 1);
    chk("wr_c2_ack0", ACK0, 0);
    tick();  // cycle 3
    chk("wr_c3_ack0", ACK0, 1);
    chk("wr_c3_gnt0", GNT0, 1);
    chk("wr_c3_state", STATE, 2);
    chk("wr_c3_gnt1", GNT1, 0);
    chk("wr_c3_ack1", ACK1, 0);
    REQ0 = 1'b0;
    tick();  // cycle 4
    chk("wr_c4_ack0", ACK0, 0);
    chk("wr_c4_gnt0", GNT0, 0);
    chk("wr_c4_state", STATE, 0);
    $display("single write: addr=012 data=1A5");

    // ---- Single read from requester 1 ----
    REQ1 = 1'b1; W1 = 1'b0; ADDR1 = 9'h040;
    tick();
    chk("rd_c1_gnt1", GNT1, 1);
    chk("rd_c1_maddr", MADDR, 9'h040);
    chk("rd_c1_mw", MW, 0);
    tick();
    chk("rd_c2_ack1", ACK1, 0);
    chk("rd_c2_rdata", RDATA, 0);
    tick();
    chk("rd_c3_ack1", ACK1, 1);
    chk("rd_c3_rdata", RDATA, 9'h0F3);
    chk("rd_c3_mw", MW, 0);
    chk("rd_c3_ack0", ACK0, 0);
    REQ1 = 1'b0;
    tick();
    chk("rd_c4_ack1", ACK1, 0);
    $display("single read: addr=040 rdata=%h", 9'h0F3);

    // ---- Read back the earlier write ----
    REQ0 = 1'b1; W0 = 1'b0; ADDR0 = 9'h012;
    tick(); tick(); tick();
    chk("rb_ack0", ACK0, 1);
    chk("rb_rdata", RDATA, 9'h1A5);
    REQ0 = 1'b0;
    tick();
    $display("readback: addr=012");

    // ---- Reset in the second ACCESS cycle ----
    REQ0 = 1'b1; W0 = 1'b0; ADDR0 = 9'h040;
    tick();  // cycle 1
    chk("ra_c1_gnt0", GNT0, 1);
    tick();  // cycle 2 (second ACCESS)
    RST = 1'b0; REQ0 = 1'b0;
    tick();
    chk("ra_ack0", ACK0, 0);
    chk("ra_mw", MW, 0);
    chk("ra_gnt0", GNT0, 0);
    chk("ra_state", STATE, 0);
    chk("ra_rdata", RDATA, 0);
    RST = 1'b1;
    tick();
    chk("ra_idle_ack0", ACK0, 0);
    $display("mid-transaction reset: aborted");

    // ---- Contention: REQ0 persistent, REQ1 once -> grants 0,1,0 ----
    REQ0 = 1'b1; W0 = 1'b1; ADDR0 = 9'h0A0; DOUT0 = 9'h055;
    REQ1 = 1'b1; W1 = 1'b0; ADDR1 = 9'h040;
    tick();  // c1
    chk("ct_c1_gnt0", GNT0, 1);
    chk("ct_c1_gnt1", GNT1, 0);
    chk("ct_c1_maddr", MADDR, 9'h0A0);
    chk("ct_c1_mw", MW, 1);
    tick();  // c2
    tick();  // c3
    chk("ct_c3_ack0", ACK0, 1);
    chk("ct_c3_ack1", ACK1, 0);
    chk("ct_c3_rdata", RDATA, 0);
    tick();  // c4 idle, both still requesting
    chk("ct_c4_state", STATE, 0);
    chk("ct_c4_gnt0", GNT0, 0);
    chk("ct_c4_gnt1", GNT1, 0);
    tick();  // c5
    chk("ct_c5_gnt1", GNT1, 1);
    chk("ct_c5_gnt0", GNT0, 0);
    chk("ct_c5_maddr", MADDR, 9'h040);
    chk("ct_c5_mw", MW, 0);
    tick();  // c6
    tick();  // c7
    chk("ct_c7_ack1", ACK1, 1);
    chk("ct_c7_ack0", ACK0, 0);
    chk("ct_c7_rdata", RDATA, 9'h0F3);
    REQ1 = 1'b0;
    tick();  // c8
    chk("ct_c8_state", STATE, 0);
    tick();  // c9
    chk("ct_c9_gnt0", GNT0, 1);
    chk("ct_c9_gnt1", GNT1, 0);
    tick();  // c10
    tick();  // c11
    chk("ct_c11_ack0", ACK0, 1);
    REQ0 = 1'b0;
    tick();  // c12
    chk("ct_c12_state", STATE, 0);
    chk("ct_c12_gnt0", GNT0, 0);
    $display("contention: order 0,1,0");

    // ---- REQ0 dropped during ACCESS still completes ----
    REQ0 = 1'b1; W0 = 1'b0; ADDR0 = 9'h0A0;
    tick();
    chk("ab_c1_gnt0", GNT0, 1);
    REQ0 = 1'b0;
    tick();
    tick();
    chk("ab_c3_ack0", ACK0, 1);
    chk("ab_c3_rdata", RDATA, 9'h055);
    tick();
    chk("ab_c4_ack0", ACK0, 0);
    tick();
    chk("ab_c5_state", STATE, 0);
    chk("ab_c5_ack0", ACK0, 0);
    $display("abandoned request: single ACK0");

    // ---- Latency sweep MEM_LAT=1 and MEM_LAT=8 ----
    req_l1 = 1'b1; req_l8 = 1'b1;
    tick();  // c1
    chk("l1_c1_state", state_l1, 1);
    chk("l8_c1_gnt0", gnt0_l8, 1);
    tick();  // c2
    chk("l1_c2_ack0", ack0_l1, 1);
    chk("l1_c2_rdata", rdata_l1, 9'h1C3);
    chk("l8_c2_ack0", ack0_l8, 0);
    req_l1 = 1'b0;
    for (int c = 3; c <= 9; c++) begin
      tick();
      chk($sformatf("l8_c%0d_ack0", c), ack0_l8, (c == 9) ? 32'd1 : 32'd0);
    end
    chk("l8_c9_rdata", rdata_l8, 9'h0B7);
    req_l8 = 1'b0;
    tick();
    chk("l8_c10_ack0", ack0_l8, 0);
    chk("l1_c10_ack0", ack0_l1, 0);
    $display("latency sweep: MEM_LAT=1 ack c2, MEM_LAT=8 ack c9");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
